imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer-side companion to the instruction memory: consumes a byte stream (e.g. from a UART receiver) and writes 32-bit instruction words into the memory's write port.
- Framing: 16-bit little-endian word count, then payload words, little-endian bytes per word.
- Holds the core in reset until the load completes, then releases it so fetch starts at BASE_ADDR.

Parameters:
- DEPTH, 1024, instruction memory depth in words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; word aligned.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; arms a new load. Honoured only in IDLE, DONE or ERR.
- byte_valid  input  1  byte_data valid this cycle; each valid cycle is consumed (no backpressure).
- byte_data  input  8  stream byte.
- mem_we  output  1  one-cycle write strobe to instruction memory.
- mem_addr  output  32  byte address of the write, word aligned (bits [1:0] = 0).
- mem_wdata  output  32  instruction word.
- load_done  output  1  high while in DONE.
- load_err  output  1  high while in ERR.
- core_rst  output  1  active-low reset to the core; 1 only in DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; load_done=0; load_err=0; core_rst=0; all counters and byte index 0.
- Reset mid-load: words already written stay in memory; the loader returns to IDLE and the core stays held.
- States: IDLE, LEN0, LEN1, DATA, CHK (only with the macro), DONE, ERR.
- IDLE: start goes to LEN0. Bytes arriving in IDLE are ignored.
- LEN0: a valid byte loads len[7:0] and the state goes to LEN1.
- LEN1: a valid byte loads len[15:8].
  - len == 0: go to DONE (or CHK with the macro, expecting checksum 8'h00).
  - len > DEPTH: go to ERR; no writes occur.
  - Otherwise: go to DATA with word_idx=0 and byte_idx=0.
- DATA byte assembly:
  - Byte i of a word goes to bits [8i+7:8i].
  - On the edge accepting byte 3, register mem_wdata (the complete word), mem_addr = BASE_ADDR + 4*word_idx, and mem_we=1 for exactly one cycle.
  - Latency: the strobe is visible during the cycle after the 4th byte edge.
- After the last word (word_idx == len-1): go to DONE (or CHK). Otherwise increment word_idx and reset byte_idx.
- Gaps: byte_valid low for any number of cycles does not change state or partial word.
- DONE and ERR: load_done/load_err and core_rst update on the same edge as the state change. core_rst rises on the edge after the final mem_we edge.
- start in DONE or ERR: go to LEN0.
  - core_rst drops to 0 and load_done/load_err clear on that edge.
  - mem_addr is left at its last value until the next write.
- start in LEN0, LEN1, DATA or CHK: ignored.
- start and byte_valid in the same IDLE cycle: the byte is ignored; LEN0 is entered.
- mem_we is never high outside DATA-originated writes; at most one strobe per 4 payload bytes.
- Address arithmetic is 32-bit; no wrap is possible because len <= DEPTH.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload word (or after LEN1 when len==0), the state goes to CHK.
  - The next valid byte is compared with the XOR of all payload bytes; the length bytes are excluded.
  - Match: go to DONE. Mismatch: go to ERR, and core_rst stays 0.
  - Written words are not rolled back.
- Not defined: the CHK state and XOR register are absent. The last write goes straight to DONE; any following bytes are ignored.

Test Plan:
- Single word: start, then bytes 01 00 03 A3 C4 FF.
  - Required: one mem_we pulse with mem_addr=0x00000000 and mem_wdata=0xFFC4A303.
  - Required: next edge load_done=1, core_rst=1, load_err=0.
- Three words with random 0-5 cycle byte gaps.
  - Required: writes at 0x0, 0x4, 0x8 with exactly three strobes and correct words.
  - Required: no strobe during gaps.
- Zero length: bytes 00 00.
  - Required: no mem_we; load_done=1 next edge.
  - With macro: a trailing 00 is required before DONE.
- Oversize: bytes 01 04 (len=1025, DEPTH=1024).
  - Required: load_err=1, core_rst=0, no writes.
  - A subsequent start plus a valid 1-word stream reaches DONE.
- Reset mid-load: assert rst after 2 payload bytes of word 0.
  - Required: all outputs immediately at reset values, no strobe.
  - After release, bytes without start are ignored.
- Checksum (macro defined): word bytes 03 A3 C4 FF.
  - Checksum 9B (03^A3^C4^FF) gives DONE.
  - Checksum 9A gives load_err=1, core_rst=0, with the word still written at 0x0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream loader for instruction memory; holds the core in reset until loaded.
// Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int          DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          load_done,
   output logic          load_err,
   output logic          core_rst
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN0 = 3'd1,
      LEN1 = 3'd2,
      DATA = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK  = 3'd4,
`endif
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   state_t      r_state, w_next;
   logic [15:0] r_len, w_len_n;
   logic [15:0] r_word_idx, w_word_n;
   logic [1:0]  r_byte_idx, w_byte_n;
   logic [23:0] r_part, w_part;
   logic        r_we, w_we;
   logic [31:0] r_addr, w_addr;
   logic [31:0] r_wdata, w_wdata;
   logic        r_fin;

   logic        w_bv;
   logic [7:0]  w_bd;
   logic [15:0] w_len;
   logic        w_len_big;
   logic        w_last;
   logic        w_arm;
   logic        w_acc;
   logic        w_wr;
   logic        w_wr_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  r_xor, w_xor_n;
`endif

   assign w_bv      = bus.byte_valid;
   assign w_bd      = bus.byte_data;
   assign w_len     = {w_bd, r_len[7:0]};
   assign w_len_big = {16'd0, w_len} > DEPTH_U;
   assign w_last    = r_word_idx == (r_len - 16'd1);
   assign w_arm     = start && (r_state == IDLE ||
                                r_state == DONE ||
                                r_state == ERR);
   // r_fin marks the strobe cycle of the final word; DONE follows it
   assign w_acc     = w_bv && r_state == DATA && !r_fin;
   assign w_wr      = w_acc && r_byte_idx == 2'd3;
   assign w_wr_last = w_wr && w_last;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_len      <= 16'd0;
         r_word_idx <= 16'd0;
         r_byte_idx <= 2'd0;
         r_part     <= 24'd0;
         r_we       <= 1'b0;
         r_addr     <= BASE_ADDR;
         r_wdata    <= 32'd0;
         r_fin      <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_len      <= w_len_n;
         r_word_idx <= w_word_n;
         r_byte_idx <= w_byte_n;
         r_part     <= w_part;
         r_we       <= w_we;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_fin      <= w_wr_last;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_xor <= 8'd0;
      else      r_xor <= w_xor_n;
   end
`endif

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (start) w_next = LEN0;
         LEN0: if (w_bv) w_next = LEN1;
         LEN1: begin
            if (w_bv) begin
               if (w_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  w_next = CHK;
`else
                  w_next = DONE;
`endif
               end else if (w_len_big) begin
                  w_next = ERR;
               end else begin
                  w_next = DATA;
               end
            end
         end
         DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_wr_last) w_next = CHK;
`else
            if (r_fin) w_next = DONE;
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         CHK: if (w_bv) w_next = (w_bd == r_xor) ? DONE : ERR;
`endif
         DONE: if (start) w_next = LEN0;
         ERR:  if (start) w_next = LEN0;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_we     = w_wr;
      w_addr   = r_addr;
      w_wdata  = r_wdata;
      w_part   = r_part;
      w_len_n  = r_len;
      w_word_n = r_word_idx;
      w_byte_n = r_byte_idx;
`ifdef IMEM_LOADER_CHECKSUM_EN
      w_xor_n  = r_xor;
      if (w_arm) w_xor_n = 8'd0;
      if (w_acc) w_xor_n = r_xor ^ w_bd;
`endif
      if (w_arm) begin
         w_word_n = 16'd0;
         w_byte_n = 2'd0;
      end
      if (r_state == LEN0 && w_bv) w_len_n[7:0] = w_bd;
      if (r_state == LEN1 && w_bv) begin
         w_len_n[15:8] = w_bd;
         w_word_n      = 16'd0;
         w_byte_n      = 2'd0;
      end
      if (w_acc) begin
         w_byte_n = r_byte_idx + 2'd1;
         unique case (r_byte_idx)
            2'd0:    w_part[7:0]   = w_bd;
            2'd1:    w_part[15:8]  = w_bd;
            2'd2:    w_part[23:16] = w_bd;
            default: w_part        = r_part;
         endcase
         if (w_wr) begin
            w_addr  = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
            w_wdata = {w_bd, r_part};
            if (!w_last) w_word_n = r_word_idx + 16'd1;
         end
      end
   end

   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign load_done     = r_state == DONE;
   assign load_err      = r_state == ERR;
   assign core_rst      = r_state == DONE;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framing, gaps, zero/oversize length, reset, checksum.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        load_done;
   logic        load_err;
   logic        core_rst;
   int          errs   = 0;
   int          checks = 0;
   int          n_we   = 0;
   logic [31:0] q_addr[$];
   logic [31:0] q_data[$];
   logic [7:0]  cks;

   imem_loader_if u_if ();

   imem_loader #(
      .DEPTH     (1024),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (u_if),
      .load_done (load_done),
      .load_err  (load_err),
      .core_rst  (core_rst)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (u_if.mem_we === 1'b1) begin
         n_we++;
         q_addr.push_back(u_if.mem_addr);
         q_data.push_back(u_if.mem_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      n_we = 0;
      q_addr.delete();
      q_data.delete();
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      u_if.byte_valid = 1'b1;
      u_if.byte_data  = b;
      @(posedge clk);
      #1;
      u_if.byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
   endtask

   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 0; i < 4; i++) begin
         send(w[8*i +: 8], int'($urandom_range(maxgap, 0)));
         cks = cks ^ w[8*i +: 8];
      end
   endtask

   task automatic arm();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cks = 8'h00;
   endtask

   task automatic chk_word(input string tag, input logic [31:0] a,
                           input logic [31:0] d);
      if (q_addr.size() == 0) begin
         chk({tag, "_present"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_addr"}, q_addr.pop_front(), a);
         chk({tag, "_data"}, q_data.pop_front(), d);
      end
   endtask

   logic [31:0] words [3];

   initial begin
      words[0] = 32'h1122_3344;
      words[1] = 32'hDEAD_BEEF;
      words[2] = 32'h0000_0013;
      rst = 1'b0;
      start = 1'b0;
      u_if.byte_valid = 1'b0;
      u_if.byte_data  = 8'h00;
      cks = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", u_if.mem_we, 0);
      chk("rst_addr", u_if.mem_addr, 0);
      chk("rst_wdata", u_if.mem_wdata, 0);
      chk("rst_done", load_done, 0);
      chk("rst_err", load_err, 0);
      chk("rst_core", core_rst, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // single word
      clr();
      arm();
      send(8'h01, 0);
      send(8'h00, 0);
      send_word(32'hFFC4_A303, 0);
      chk("t1_we", u_if.mem_we, 1);
      chk("t1_addr", u_if.mem_addr, 32'h0);
      chk("t1_wdata", u_if.mem_wdata, 32'hFFC4_A303);
      chk("t1_done_early", load_done, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h9B, 0);
`else
      @(posedge clk);
      #1;
`endif
      chk("t1_done", load_done, 1);
      chk("t1_core", core_rst, 1);
      chk("t1_err", load_err, 0);
      chk("t1_we_off", u_if.mem_we, 0);
      chk("t1_nwe", n_we, 1);

      // three words with gaps
      clr();
      arm();
      chk("t2_core_drop", core_rst, 0);
      chk("t2_done_drop", load_done, 0);
      send(8'h03, 2);
      send(8'h00, 1);
      for (int k = 0; k < 3; k++) send_word(words[k], 5);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("t2_cks_model", {24'd0, cks}, 32'h75);
      send(cks, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("t2_nwe", n_we, 3);
      chk_word("t2_w0", 32'h0, words[0]);
      chk_word("t2_w1", 32'h4, words[1]);
      chk_word("t2_w2", 32'h8, words[2]);
      chk("t2_done", load_done, 1);

      // zero length
      clr();
      arm();
      send(8'h00, 0);
      send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("t3_wait_cks", load_done, 0);
      send(8'h00, 0);
`endif
      chk("t3_done", load_done, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("t3_nwe", n_we, 0);

      // oversize, then recovery
      clr();
      arm();
      send(8'h01, 0);
      send(8'h04, 0);
      chk("t4_err", load_err, 1);
      chk("t4_core", core_rst, 0);
      send_word(32'hCAFE_F00D, 0);
      chk("t4_nwe", n_we, 0);
      arm();
      chk("t4_err_clr", load_err, 0);
      send(8'h01, 1);
      send(8'h00, 0);
      send_word(32'h1234_5678, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h08, 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("t4_done", load_done, 1);
      chk_word("t4_w0", 32'h0, 32'h1234_5678);

      // reset mid-load
      clr();
      arm();
      send(8'h02, 0);
      send(8'h00, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      rst = 1'b0;
      #1;
      chk("t5_we", u_if.mem_we, 0);
      chk("t5_addr", u_if.mem_addr, 0);
      chk("t5_wdata", u_if.mem_wdata, 0);
      chk("t5_done", load_done, 0);
      chk("t5_err", load_err, 0);
      chk("t5_core", core_rst, 0);
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send(8'h01, 0);
      send(8'h00, 0);
      send_word(32'h0102_0304, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t5_nwe", n_we, 0);
      chk("t5_idle_core", core_rst, 0);
      chk("t5_idle_done", load_done, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // bad checksum
      clr();
      arm();
      send(8'h01, 0);
      send(8'h00, 0);
      send_word(32'hFFC4_A303, 0);
      send(8'h9A, 0);
      chk("t6_err", load_err, 1);
      chk("t6_core", core_rst, 0);
      chk_word("t6_w0", 32'h0, 32'hFFC4_A303);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
